bcd_serial_add_ctrl: RTL

- Sequential controller for a multi-digit packed-BCD add.
- Time-shares one existing `full_adder_4bit` instance across all digits, least significant digit (LSD) first.
- Each digit takes two adder passes: a binary add (a + b + carry), then a +6 decimal correction when needed.
- Operands are latched on a start/done handshake. The block sits between the operand source and the result consumer in the BCD adder path.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/full_adder_4bit.sv | 15 +
 rtl/bcd_serial_add_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial packed-BCD adder controller.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

  // A BCD digit is only meaningful up to 9; anything above makes the result undefined.
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// Plain 4-bit binary adder with carry in/out, shared by all digit passes.
module full_adder_4bit (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  // Single binary add; the 5-bit result is split into sum and carry.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one shared 4-bit adder, LSD first, binary add then +6 fix per digit.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     a_bcd,
  input  logic [4*DIGITS-1:0]     b_bcd,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     sum_bcd,
  output logic                    cout,
  output logic                    err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [4:0]         raw_q, raw_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               cout_q, cout_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

  logic [3:0]         fa_a_s, fa_b_s, fa_sum_s, digit_s;
  logic               fa_cin_s, fa_cout_s, carry_nxt_s, bad_s, fix_s;

  full_adder_4bit u_fa (
    .s    (fa_sum_s),
    .cout (fa_cout_s),
    .a    (fa_a_s),
    .b    (fa_b_s),
    .cin  (fa_cin_s)
  );

  assign fix_s = (raw_q > {1'b0, BCD_MAX});

  // Shared adder operand mux, selected purely from registered state.
  always_comb begin
    fa_a_s   = 4'd0;
    fa_b_s   = 4'd0;
    fa_cin_s = 1'b0;
    case (state_q)
      ADD: begin
        fa_a_s   = a_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        fa_b_s   = b_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        fa_cin_s = carry_q;
      end
      CORR: begin
        if (fix_s) begin
          fa_a_s = raw_q[3:0];
          fa_b_s = BCD_CORR;
        end else begin
          fa_a_s = 4'd0;
          fa_b_s = 4'd0;
        end
      end
      default: begin
        fa_a_s = 4'd0;
      end
    endcase
  end

  // Any out-of-range digit in the incoming operands flags the result as non-BCD.
  always_comb begin
    bad_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_s = bad_s | digit_invalid(a_bcd[i*DIGIT_W +: DIGIT_W])
                    | digit_invalid(b_bcd[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state, datapath updates and registered output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    raw_d       = raw_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    digit_s     = raw_q[3:0];
    carry_nxt_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_bcd;
          b_d     = b_bcd;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = bad_s;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        raw_d   = {fa_cout_s, fa_sum_s};
        state_d = CORR;
      end
      CORR: begin
        if (fix_s) begin
          digit_s     = fa_sum_s;
          carry_nxt_s = 1'b1;
        end else begin
          digit_s     = raw_q[3:0];
          carry_nxt_s = 1'b0;
        end
        sum_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = digit_s;
        carry_d = carry_nxt_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = carry_nxt_s;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ADD) || (state_d == CORR);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything including outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      raw_q   <= 5'd0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      raw_q   <= raw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_bcd = sum_q;
  assign cout    = cout_q;
  assign err     = err_q;

endmodule
